regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- Write-port arbiter and register scoreboard for the stage2 32x32 register file.
- Shares the single register-file write port between the in-order writeback path (WB) and a long-latency unit (LU, e.g. multiply/divide or miss-load) that returns results out of band.
- Tracks destination registers with outstanding LU results and stalls ID on RAW/WAW hazards against them.
- Sits between stage5 writeback, the LU result return, and the register-file write port; `stall_out` feeds the stage2 pipeline control.

Parameters:
- LU_FIFO_DEPTH, 2: entries in the LU result buffer; power of two, minimum 2.
- MAX_PENDING, 8: maximum outstanding LU destinations; range 1..31.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_rs_en  in  1  ID reads rs this cycle
- id_rs_addr  in  5  rs address
- id_rt_en  in  1  ID reads rt this cycle
- id_rt_addr  in  5  rt address
- id_issue_valid  in  1  instruction in ID issues this cycle if not stalled
- id_issue_long  in  1  issuing instruction writes through the LU
- id_issue_dest  in  5  LU destination register
- stall_out  out  1  hold ID/IF, insert bubble
- wb_wr_en  in  1  WB write request, always granted
- wb_wr_addr  in  5  WB destination
- wb_wr_data  in  32  WB data
- lu_valid  in  1  LU result valid
- lu_ready  out  1  LU result accepted when lu_valid && lu_ready
- lu_addr  in  5  LU destination
- lu_data  in  32  LU data
- rf_wr_en  out  1  register-file write enable
- rf_wr_addr  out  5  register-file write address
- rf_wr_data  out  32  register-file write data
- pending_cnt  out  6  number of set pending bits
- err_waw  out  1  sticky: WB wrote a pending register

Behaviour:
- Reset (async): pending bitmap = 0, FIFO empty (rd/wr pointers and count = 0), pending_cnt = 0, err_waw = 0. Outputs then evaluate to stall_out = 0, lu_ready = 1, rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0. Reset mid-operation flushes all buffered LU results and pending bits.
- Pending bitmap (32 bits):
  - Bit 0 is hard-wired 0.
  - Set on the clock edge when id_issue_valid && id_issue_long && !stall_out && id_issue_dest != 0.
  - Cleared on the edge where a FIFO-head entry is written to the register file.
- Stall (combinational): stall_out = 1 when any of the following holds:
  - RAW: (id_rs_en && pend[id_rs_addr]) || (id_rt_en && pend[id_rt_addr]).
  - WAW: id_issue_valid && id_issue_long && pend[id_issue_dest].
  - Capacity: id_issue_valid && id_issue_long && pending_cnt == MAX_PENDING.
  - Address 0 never stalls.
- Set and clear of the same register in the same cycle is impossible by construction: set requires the bit to be clear, clear requires it to be set.
- LU FIFO:
  - lu_ready = (count < LU_FIFO_DEPTH). Push on lu_valid && lu_ready.
  - Entries are stored in arrival order; pointers wrap modulo LU_FIFO_DEPTH.
  - An LU result with lu_addr == 0 is accepted and discarded: no push, no write.
- Write-port arbitration (combinational), WB has fixed priority:
  - wb_wr_en = 1: rf_wr_* = WB signals; the FIFO head waits.
  - wb_wr_en = 0 and FIFO non-empty: rf_wr_* = head entry, with pop and pending clear on the edge.
  - Neither source active: rf_wr_en = 0, addr/data = 0.
- Simultaneous push and pop keeps count unchanged, including when full: lu_ready reflects the pre-pop count, so no push occurs while full.
- Same-cycle push into an empty FIFO is not written that cycle; minimum LU-to-register-file latency is 1 cycle.
- pending_cnt is a registered counter: +1 on set, −1 on clear, unchanged when both occur in the same cycle. It never exceeds MAX_PENDING.
- err_waw is set on the edge where wb_wr_en && wb_wr_addr != 0 && pend[wb_wr_addr]. It is cleared only by reset. The write itself still proceeds.

Optional Feature:
- SB_BYPASS_EN defined: the RAW stall term ignores the pending bit of the address being written from the FIFO head this cycle. The register file already forwards same-cycle write data to its read ports, so the dependent instruction issues with 0 extra cycles.
- Not defined: the pending bit is consulted as registered, and the dependent instruction stalls until the cycle after the write (1 extra cycle).

Test Plan:
- Issue long dest=5; next cycle id_rs_addr=5, id_rs_en=1 → stall_out=1, pending_cnt=1. Then LU returns addr=5, data=0xDEADBEEF with WB idle → rf_wr_en=1, addr=5, data=0xDEADBEEF one cycle later. stall_out drops in the same cycle with SB_BYPASS_EN, the cycle after without.
- WB writes r3 every cycle for 4 cycles while LU pushes r7=0x11, r8=0x22, r9=0x33 → lu_ready=0 after 2 pushes. After WB idles: r7 then r8 written, then r9 accepted and written; ordering preserved.
- 8 long issues to r1..r8 → pending_cnt=8. 9th long issue (dest r9) → stall_out=1. After one LU result clears → issues.
- Long issue dest=0 and LU result addr=0 → pend unchanged, pending_cnt=0, no rf write, no stall on reads of r0.
- Pending r4; WB writes r4=0x1234 → err_waw=1 and stays 1; rf write of 0x1234 still occurs.
- Two long results buffered and pending_cnt=2, assert rst_n=0 mid-stream → immediately rf_wr_en=0, stall_out=0, pending_cnt=0, lu_ready=1; no buffered write appears after release.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write-port arbiter (WB priority over a buffered LU return path) plus a
// pending-destination scoreboard that stalls ID on hazards. Optional macro: SB_BYPASS_EN.
module regfile_wb_scoreboard #(
    parameter int unsigned LU_FIFO_DEPTH = 2,
    parameter int unsigned MAX_PENDING   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_rs_en,
    input  logic [4:0]  id_rs_addr,
    input  logic        id_rt_en,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_issue_valid,
    input  logic        id_issue_long,
    input  logic [4:0]  id_issue_dest,
    output logic        stall_out,
    input  logic        wb_wr_en,
    input  logic [4:0]  wb_wr_addr,
    input  logic [31:0] wb_wr_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic [5:0]  pending_cnt,
    output logic        err_waw
);

    localparam int unsigned PTR_W = (LU_FIFO_DEPTH > 1) ? $clog2(LU_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      pend_q;
    logic [31:0]      pend_d;
    logic [31:0]      pend_raw;
    logic [31:0]      wr_mask;
    logic [4:0]       fifo_addr [LU_FIFO_DEPTH];
    logic [31:0]      fifo_data [LU_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [4:0]       head_addr;
    logic             push;
    logic             pop;
    logic             set_pend;
    logic             clr_pend;
    logic             long_issue;

    assign head_addr  = fifo_addr[rd_ptr];
    assign lu_ready   = (count < CNT_W'(LU_FIFO_DEPTH));
    assign push       = lu_valid && lu_ready && (lu_addr != 5'd0);
    assign pop        = !wb_wr_en && (count != '0);
    assign long_issue = id_issue_valid && id_issue_long;
    assign set_pend   = long_issue && !stall_out && (id_issue_dest != 5'd0);
    assign clr_pend   = pop && pend_q[head_addr];

    // Write-port arbitration: WB always wins, FIFO head drains on idle WB cycles
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = 5'd0;
        rf_wr_data = 32'd0;
        if (wb_wr_en) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = wb_wr_addr;
            rf_wr_data = wb_wr_data;
        end else if (pop) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = head_addr;
            rf_wr_data = fifo_data[rd_ptr];
        end
    end

    // RAW view of the scoreboard; the bypass build hides the register being drained now
    always_comb begin
        wr_mask = 32'd0;
        if (pop) begin
            wr_mask[head_addr] = 1'b1;
        end
`ifdef SB_BYPASS_EN
        pend_raw = pend_q & ~wr_mask;
`else
        pend_raw = pend_q;
`endif
    end

    always_comb begin
        stall_out = 1'b0;
        if ((id_rs_en && pend_raw[id_rs_addr]) || (id_rt_en && pend_raw[id_rt_addr])) begin
            stall_out = 1'b1;
        end
        if (long_issue && (pend_q[id_issue_dest] || (pending_cnt == 6'(MAX_PENDING)))) begin
            stall_out = 1'b1;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (set_pend) begin
            pend_d[id_issue_dest] = 1'b1;
        end
        if (clr_pend) begin
            pend_d[head_addr] = 1'b0;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 32'd0;
            pending_cnt <= 6'd0;
            err_waw     <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (set_pend && !clr_pend) begin
                pending_cnt <= pending_cnt + 6'd1;
            end else if (clr_pend && !set_pend) begin
                pending_cnt <= pending_cnt - 6'd1;
            end
            if (wb_wr_en && (wb_wr_addr != 5'd0) && pend_q[wb_wr_addr]) begin
                err_waw <= 1'b1;
            end
        end
    end

    // FIFO control; pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset: entries are only read when count says they are valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lu_addr;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Self-checking bench for regfile_wb_scoreboard: directed scenarios plus a randomized run
// against a queue-based reference model. Honours SB_BYPASS_EN when defined.
module tb_regfile_wb_scoreboard;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned MAXP   = 8;
`ifdef SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_rs_en, id_rt_en, id_issue_valid, id_issue_long;
    logic [4:0]  id_rs_addr, id_rt_addr, id_issue_dest;
    logic        stall_out;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_addr;
    logic [31:0] wb_wr_data;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [5:0]  pending_cnt;
    logic        err_waw;

    int checks = 0;
    int errors = 0;

    regfile_wb_scoreboard #(.LU_FIFO_DEPTH(DEPTH), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_en(id_rs_en), .id_rs_addr(id_rs_addr),
        .id_rt_en(id_rt_en), .id_rt_addr(id_rt_addr),
        .id_issue_valid(id_issue_valid), .id_issue_long(id_issue_long),
        .id_issue_dest(id_issue_dest), .stall_out(stall_out),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .pending_cnt(pending_cnt), .err_waw(err_waw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs_en = 0; id_rs_addr = 0; id_rt_en = 0; id_rt_addr = 0;
        id_issue_valid = 0; id_issue_long = 0; id_issue_dest = 0;
        wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic issue_long(input logic [4:0] dest);
        id_issue_valid = 1; id_issue_long = 1; id_issue_dest = dest;
        tick();
        id_issue_valid = 0; id_issue_long = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        checks++;
        if ({stall_out, lu_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pending_cnt, err_waw} !==
            {1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b rdy=%b en=%b a=%0d d=%h cnt=%0d err=%b",
                     stall_out, lu_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pending_cnt, err_waw);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_raw_stall();
        do_reset();
        issue_long(5'd5);
        id_rs_en = 1; id_rs_addr = 5;
        lu_valid = 1; lu_addr = 5; lu_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (stall_out !== 1'b1 || pending_cnt !== 6'd1 || rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall got stall=%b cnt=%0d en=%b exp 1 1 0", stall_out, pending_cnt, rf_wr_en);
        end
        tick();
        lu_valid = 0;
        #1;
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lu_write got en=%b a=%0d d=%h exp 1 5 deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
        end
        checks++;
        if (stall_out !== !BYPASS) begin
            errors++;
            $display("FAIL raw_release_same_cycle got %b exp %b", stall_out, !BYPASS);
        end
        tick();
        #1;
        checks++;
        if (stall_out !== 1'b0 || rf_wr_en !== 1'b0 || pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL raw_after got stall=%b en=%b cnt=%0d exp 0 0 0", stall_out, rf_wr_en, pending_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_fifo_order();
        logic [4:0]  qa [3];
        logic [31:0] qd [3];
        int          k;
        qa[0] = 7; qa[1] = 8; qa[2] = 9;
        qd[0] = 32'h11; qd[1] = 32'h22; qd[2] = 32'h33;
        do_reset();
        issue_long(5'd7); issue_long(5'd8); issue_long(5'd9);
        k = 0;
        for (int c = 0; c < 4; c++) begin
            wb_wr_en = 1; wb_wr_addr = 3; wb_wr_data = 32'(c);
            lu_valid = 1; lu_addr = qa[k]; lu_data = qd[k];
            #1;
            checks++;
            if (rf_wr_addr !== 5'd3 || rf_wr_data !== 32'(c) || lu_ready !== (c < 2)) begin
                errors++;
                $display("FAIL wb_priority c=%0d got a=%0d d=%h rdy=%b", c, rf_wr_addr, rf_wr_data, lu_ready);
            end
            if (lu_ready) k++;
            tick();
        end
        wb_wr_en = 0;
        for (int c = 0; c < 3; c++) begin
            if (k < 3) begin
                lu_valid = 1; lu_addr = qa[k]; lu_data = qd[k];
            end else begin
                lu_valid = 0;
            end
            #1;
            checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_addr !== qa[c] || rf_wr_data !== qd[c]) begin
                errors++;
                $display("FAIL drain_order c=%0d got en=%b a=%0d d=%h exp a=%0d d=%h",
                         c, rf_wr_en, rf_wr_addr, rf_wr_data, qa[c], qd[c]);
            end
            if (c == 0) begin
                checks++;
                if (lu_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_during_pop got %b exp 0", lu_ready);
                end
            end
            if (lu_valid && lu_ready) k++;
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (rf_wr_en !== 1'b0 || pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL drain_done got en=%b cnt=%0d exp 0 0", rf_wr_en, pending_cnt);
        end
    endtask

    task automatic test_capacity();
        do_reset();
        for (int r = 1; r <= 8; r++) begin
            id_issue_valid = 1; id_issue_long = 1; id_issue_dest = 5'(r);
            #1;
            checks++;
            if (stall_out !== 1'b0) begin
                errors++;
                $display("FAIL cap_fill r=%0d got stall=%b exp 0", r, stall_out);
            end
            tick();
        end
        id_issue_dest = 9;
        #1;
        checks++;
        if (pending_cnt !== 6'd8 || stall_out !== 1'b1) begin
            errors++;
            $display("FAIL cap_full got cnt=%0d stall=%b exp 8 1", pending_cnt, stall_out);
        end
        lu_valid = 1; lu_addr = 1; lu_data = 32'hA5;
        tick();
        lu_valid = 0;
        #1;
        checks++;
        if (stall_out !== 1'b1 || rf_wr_addr !== 5'd1) begin
            errors++;
            $display("FAIL cap_pop got stall=%b a=%0d exp 1 1", stall_out, rf_wr_addr);
        end
        tick();
        #1;
        checks++;
        if (stall_out !== 1'b0 || pending_cnt !== 6'd7) begin
            errors++;
            $display("FAIL cap_release got stall=%b cnt=%0d exp 0 7", stall_out, pending_cnt);
        end
        tick();
        id_issue_valid = 0; id_issue_long = 0;
        #1;
        checks++;
        if (pending_cnt !== 6'd8) begin
            errors++;
            $display("FAIL cap_reissue got cnt=%0d exp 8", pending_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_zero_addr();
        do_reset();
        id_issue_valid = 1; id_issue_long = 1; id_issue_dest = 0;
        lu_valid = 1; lu_addr = 0; lu_data = 32'hFFFF;
        #1;
        checks++;
        if (stall_out !== 1'b0 || lu_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_issue got stall=%b rdy=%b exp 0 1", stall_out, lu_ready);
        end
        tick();
        idle_inputs();
        id_rs_en = 1; id_rt_en = 1;
        #1;
        checks++;
        if (pending_cnt !== 6'd0 || rf_wr_en !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL zero_after got cnt=%0d en=%b stall=%b exp 0 0 0", pending_cnt, rf_wr_en, stall_out);
        end
        idle_inputs();
    endtask

    task automatic test_err_waw();
        do_reset();
        issue_long(5'd4);
        wb_wr_en = 1; wb_wr_addr = 4; wb_wr_data = 32'h1234;
        #1;
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd4 || rf_wr_data !== 32'h1234 || err_waw !== 1'b0) begin
            errors++;
            $display("FAIL waw_write got en=%b a=%0d d=%h err=%b", rf_wr_en, rf_wr_addr, rf_wr_data, err_waw);
        end
        tick();
        wb_wr_en = 0;
        tick();
        #1;
        checks++;
        if (err_waw !== 1'b1 || pending_cnt !== 6'd1) begin
            errors++;
            $display("FAIL waw_sticky got err=%b cnt=%0d exp 1 1", err_waw, pending_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_long(5'd10); issue_long(5'd11);
        wb_wr_en = 1; wb_wr_addr = 20;
        lu_valid = 1; lu_addr = 10; lu_data = 32'hAA;
        tick();
        lu_addr = 11; lu_data = 32'hBB;
        tick();
        lu_valid = 0;
        #1;
        checks++;
        if (pending_cnt !== 6'd2 || lu_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup got cnt=%0d rdy=%b exp 2 0", pending_cnt, lu_ready);
        end
        wb_wr_en = 0; id_rs_en = 1; id_rs_addr = 10;
        rst_n = 0;
        #1;
        checks++;
        if (rf_wr_en !== 1'b0 || stall_out !== 1'b0 || pending_cnt !== 6'd0 || lu_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got en=%b stall=%b cnt=%0d rdy=%b exp 0 0 0 1",
                     rf_wr_en, stall_out, pending_cnt, lu_ready);
        end
        tick();
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (rf_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL mid_flush c=%0d got en=%b exp 0", c, rf_wr_en);
            end
        end
        idle_inputs();
    endtask

    // Reference model: set of pending registers, FIFO of LU results, list of unreturned dests
    task automatic test_random();
        logic [31:0] pend_m;
        logic [4:0]  qa [$];
        logic [31:0] qd [$];
        logic [4:0]  outst [$];
        bit          err_m, pop_m, push_m, set_m, stall_e;
        logic [31:0] raw_m;
        logic [4:0]  ea;
        logic [31:0] ed;
        int          idx;
        do_reset();
        pend_m = 0; err_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            id_rs_en = 1'($urandom_range(0, 1)); id_rs_addr = 5'($urandom_range(0, 15));
            id_rt_en = 1'($urandom_range(0, 1)); id_rt_addr = 5'($urandom_range(0, 15));
            id_issue_valid = 1'($urandom_range(0, 1)); id_issue_long = 1'($urandom_range(0, 1));
            id_issue_dest = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
            wb_wr_en = ($urandom_range(0, 2) == 0);
            wb_wr_addr = ($urandom_range(0, 99) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(16, 31));
            wb_wr_data = $urandom;
            idx = -1;
            lu_valid = 0; lu_addr = 0; lu_data = $urandom;
            if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = int'($urandom_range(0, outst.size() - 1));
                lu_valid = 1; lu_addr = outst[idx];
            end else if ($urandom_range(0, 19) == 0) begin
                lu_valid = 1; lu_addr = 0;
            end
            pop_m = !wb_wr_en && qa.size() > 0;
            raw_m = pend_m;
            if (BYPASS && pop_m) raw_m[qa[0]] = 1'b0;
            stall_e = (id_rs_en && raw_m[id_rs_addr]) || (id_rt_en && raw_m[id_rt_addr]) ||
                      (id_issue_valid && id_issue_long &&
                       (pend_m[id_issue_dest] || $countones(pend_m) == MAXP));
            ea = wb_wr_en ? wb_wr_addr : (pop_m ? qa[0] : 5'd0);
            ed = wb_wr_en ? wb_wr_data : (pop_m ? qd[0] : 32'd0);
            #1;
            checks++;
            if (stall_out !== stall_e || lu_ready !== (qa.size() < DEPTH) ||
                rf_wr_en !== (wb_wr_en || pop_m) || rf_wr_addr !== ea || rf_wr_data !== ed ||
                pending_cnt !== 6'($countones(pend_m)) || err_waw !== err_m) begin
                errors++;
                $display("FAIL random cyc=%0d got stall=%b rdy=%b en=%b a=%0d d=%h cnt=%0d err=%b exp %b %b %b %0d %h %0d %b",
                         cyc, stall_out, lu_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pending_cnt, err_waw,
                         stall_e, qa.size() < DEPTH, wb_wr_en || pop_m, ea, ed, $countones(pend_m), err_m);
            end
            push_m = lu_valid && (qa.size() < DEPTH);
            set_m = id_issue_valid && id_issue_long && !stall_e && id_issue_dest != 0;
            if (wb_wr_en && wb_wr_addr != 0 && pend_m[wb_wr_addr]) err_m = 1;
            if (pop_m) begin
                pend_m[qa[0]] = 1'b0;
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (push_m && lu_addr != 0) begin
                qa.push_back(lu_addr);
                qd.push_back(lu_data);
            end
            if (push_m && idx >= 0) outst.delete(idx);
            if (set_m) begin
                pend_m[id_issue_dest] = 1'b1;
                outst.push_back(id_issue_dest);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1;
        #2;
        test_reset();
        test_raw_stall();
        test_fifo_order();
        test_capacity();
        test_zero_addr();
        test_err_waw();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
